timer_array: RTL and testbench
==============================

TIMER_ARRAY -- requirements
Module: timer_array

Interface
REQ-001 Parameter NUM_TIMERS, default 4, number of independent timer channels (1..8).
REQ-002 Parameter COUNT_W, default 32, width of preset and count registers (8..32).
REQ-003 Parameter AW, default $clog2(NUM_TIMERS)+2, word-address width; addr[1:0] = register, addr[AW-1:2] = channel.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 addr  input  AW  word address from bridge.
REQ-007 we  input  1  write strobe, one write per cycle asserted.
REQ-008 BE  input  4  byte enables for write data.
REQ-009 WD  input  32  write data.
REQ-010 RD  output  32  read data, combinational from addr.
REQ-011 IRQ  output  NUM_TIMERS  per-channel interrupt, bit i = pending[i] & IM[i].
REQ-012 IRQ_any  output  1  OR of IRQ.

Function
REQ-013 Register map per channel: 0 CTRL (RW), 1 PRESET (RW), 2 COUNT (RO), 3 STATUS (bit0 pending, write-1-to-clear).
REQ-014 CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 10 free-run, 11 reserved = one-shot), [3] IM; others read 0; written only when BE[0].
REQ-015 PRESET written byte-wise per BE; bits above COUNT_W ignored, read 0.
REQ-016 Writes to COUNT ignored; reads of channels >= NUM_TIMERS return 0, writes ignored.
REQ-017 Per-channel FSM states IDLE, LOAD, COUNT.
REQ-018 IDLE -> LOAD on cycle after a CTRL write with EN=1; LOAD copies PRESET into COUNT, then -> COUNT next cycle.
REQ-019 COUNT: if count != 0, count decrements by 1 per cycle.
REQ-020 COUNT with count == 0: pending set; one-shot clears EN, goes IDLE, count holds 0; auto-reload reloads PRESET same edge, stays COUNT (period PRESET+1 cycles).
REQ-021 Free-run: count decrements modulo 2^COUNT_W, pending set on each 0 -> all-ones wrap, never stops while EN.
REQ-022 CTRL write with EN=0 from any state: -> IDLE next edge, count frozen, pending unchanged.
REQ-023 PRESET write during COUNT affects only the next LOAD/reload.
REQ-024 Simultaneous hardware set and STATUS W1C of the same channel: set wins, pending stays 1.
REQ-025 IM=0 masks IRQ only; pending still sets and reads back.
REQ-026 IRQ registered-free: follows pending/IM combinationally, asserted the cycle after count reaches 0.

Reset
REQ-027 On reset low, immediately: all CTRL=0, PRESET=0, COUNT=0, pending=0, FSM=IDLE, IRQ=0, IRQ_any=0.
REQ-028 Reset asserted mid-count aborts with no pending set; after release all channels wait in IDLE for a CTRL write.

Structure
REQ-029 Shared package timer_pkg holds register offsets, CTRL bit positions, MODE encodings and FSM state typedef.
REQ-030 One sub-module timer_channel (single channel FSM, registers, pending) instantiated NUM_TIMERS times; top decodes addr and muxes RD.

Verification
REQ-031 Ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> COUNT 5..0 over following cycles, IRQ[0]=1 exactly 7 cycles after write, EN reads 0, count holds 0.
REQ-032 Ch1 PRESET=3, CTRL=0xB (auto-reload) -> IRQ pulses pending every 4 cycles; W1C STATUS between events clears; W1C on the set cycle leaves pending=1.
REQ-033 Ch2 COUNT_W=8 instance, free-run from PRESET=2 -> pending set on 0x00 -> 0xFF wrap, counting continues.
REQ-034 Ch3 IM=0, PRESET=1 -> STATUS reads 1, IRQ[3]=0, IRQ_any=0; then set IM -> IRQ[3]=1 same cycle.
REQ-035 Reset pulsed low mid-count on ch0 (count=2) -> all outputs 0 asynchronously, no IRQ after release.
REQ-036 Write/read channel 5 with NUM_TIMERS=4 wrapped into 3-bit channel field -> RD=0, no channel state changes; PRESET write with BE=0x2 alters only bits 15:8.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer array: register offsets, CTRL fields,
// mode encodings, channel FSM states and the byte-lane merge helper.
package timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    typedef enum logic [1:0] {
        MODE_ONE_SHOT    = 2'b00,
        MODE_AUTO_RELOAD = 2'b01,
        MODE_FREE_RUN    = 2'b10,
        MODE_RESERVED    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_COUNT = 2'b10
    } state_e;

    // Replace each byte lane of old_v with wr_v where its enable is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] wr_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? wr_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, IDLE/LOAD/COUNT FSM
// and the pending flag with write-1-to-clear.
module timer_channel
    import timer_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [1:0]  reg_sel,
    input  logic [3:0]  be,
    input  logic [31:0] wd,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};

    state_e               state_r, state_nxt_s;
    mode_e                mode_r, mode_nxt_s;
    logic                 en_r, en_nxt_s;
    logic                 im_r, im_nxt_s;
    logic                 pending_r, pending_nxt_s;
    logic [COUNT_W-1:0]   preset_r, preset_nxt_s;
    logic [COUNT_W-1:0]   count_r, count_nxt_s;
    logic [31:0]          preset_ext_s;
    logic [31:0]          preset_merged_s;
    logic                 ctrl_wr_s;
    logic                 preset_wr_s;
    logic                 status_clr_s;

    assign ctrl_wr_s       = wr_en && (reg_sel == REG_CTRL) && be[0];
    assign preset_wr_s     = wr_en && (reg_sel == REG_PRESET);
    assign status_clr_s    = wr_en && (reg_sel == REG_STATUS) && be[0] && wd[0];
    assign preset_ext_s    = 32'(preset_r);
    assign preset_merged_s = byte_merge(preset_ext_s, wd, be);
    assign irq             = pending_r && im_r;

    // Next-state logic: register writes, then FSM, then the disable override.
    always_comb begin
        state_nxt_s   = state_r;
        mode_nxt_s    = mode_r;
        en_nxt_s      = en_r;
        im_nxt_s      = im_r;
        pending_nxt_s = pending_r;
        preset_nxt_s  = preset_r;
        count_nxt_s   = count_r;

        if (ctrl_wr_s) begin
            en_nxt_s   = wd[CTRL_EN];
            mode_nxt_s = mode_e'(wd[CTRL_MODE_HI:CTRL_MODE_LO]);
            im_nxt_s   = wd[CTRL_IM];
        end else begin
            en_nxt_s = en_r;
        end

        if (preset_wr_s) begin
            preset_nxt_s = preset_merged_s[COUNT_W-1:0];
        end else begin
            preset_nxt_s = preset_r;
        end

        // Clear first so a same-cycle expiry below wins over the W1C.
        if (status_clr_s) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (ctrl_wr_s && wd[CTRL_EN]) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_nxt_s = preset_r;
                state_nxt_s = ST_COUNT;
            end
            ST_COUNT: begin
                if (count_r != CNT_ZERO) begin
                    count_nxt_s = count_r - CNT_ONE;
                end else begin
                    pending_nxt_s = 1'b1;
                    case (mode_r)
                        MODE_AUTO_RELOAD: count_nxt_s = preset_r;
                        MODE_FREE_RUN:    count_nxt_s = count_r - CNT_ONE;
                        default: begin
                            en_nxt_s    = 1'b0;
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Disabling stops the channel where it is without touching pending.
        if (ctrl_wr_s && !wd[CTRL_EN]) begin
            state_nxt_s = ST_IDLE;
            count_nxt_s = count_r;
        end else begin
            count_nxt_s = count_nxt_s;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mode_r    <= MODE_ONE_SHOT;
            en_r      <= 1'b0;
            im_r      <= 1'b0;
            pending_r <= 1'b0;
            preset_r  <= CNT_ZERO;
            count_r   <= CNT_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            mode_r    <= mode_nxt_s;
            en_r      <= en_nxt_s;
            im_r      <= im_nxt_s;
            pending_r <= pending_nxt_s;
            preset_r  <= preset_nxt_s;
            count_r   <= count_nxt_s;
        end
    end

    // Register read-back for the selected offset.
    always_comb begin
        rd_data = 32'h0000_0000;
        case (reg_sel)
            REG_CTRL:   rd_data = {28'h000_0000, im_r, mode_r, en_r};
            REG_PRESET: rd_data = preset_ext_s;
            REG_COUNT:  rd_data = 32'(count_r);
            REG_STATUS: rd_data = {31'h0000_0000, pending_r};
            default:    rd_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/timer_array.sv
// Array of NUM_TIMERS timer channels behind a word-addressed register bus;
// decodes the channel field, muxes read data and gathers interrupts.
module timer_array
    import timer_pkg::*;
#(
    parameter int NUM_TIMERS = 4,
    parameter int COUNT_W    = 32,
    parameter int AW         = $clog2(NUM_TIMERS) + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         addr,
    input  logic                  we,
    input  logic [3:0]            BE,
    input  logic [31:0]           WD,
    output logic [31:0]           RD,
    output logic [NUM_TIMERS-1:0] IRQ,
    output logic                  IRQ_any
);

    localparam int CH_W = (AW > 2) ? AW - 2 : 1;

    logic [CH_W-1:0]       ch_s;
    logic                  ch_valid_s;
    logic [1:0]            reg_s;
    logic [31:0]           ch_rd_s [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] irq_s;
    logic [31:0]           rd_s;

    assign reg_s = addr[1:0];

    generate
        if (AW > 2) begin : g_ch_field
            assign ch_s = addr[AW-1:2];
        end else begin : g_ch_single
            assign ch_s = {CH_W{1'b0}};
        end
    endgenerate

    // Channel indices beyond the implemented count read zero and drop writes.
    assign ch_valid_s = ({{(32-CH_W){1'b0}}, ch_s} < 32'(NUM_TIMERS));

    generate
        for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
            logic wr_sel_s;
            assign wr_sel_s = we && ch_valid_s && (ch_s == CH_W'(i));

            timer_channel #(
                .COUNT_W (COUNT_W)
            ) u_chan (
                .clk     (clk),
                .rst_n   (reset),
                .wr_en   (wr_sel_s),
                .reg_sel (reg_s),
                .be      (BE),
                .wd      (WD),
                .rd_data (ch_rd_s[i]),
                .irq     (irq_s[i])
            );
        end
    endgenerate

    // Read-data mux over channels.
    always_comb begin
        rd_s = 32'h0000_0000;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (ch_valid_s && (ch_s == CH_W'(i))) begin
                rd_s = ch_rd_s[i];
            end else begin
                rd_s = rd_s;
            end
        end
    end

    assign RD      = rd_s;
    assign IRQ     = irq_s;
    assign IRQ_any = |irq_s;

endmodule

// File: tb/tb_timer_array.sv
// Directed self-checking bench for timer_array: one-shot, auto-reload,
// masking, out-of-range channels, byte writes, 8-bit free-run and reset abort.
module tb_timer_array;

    logic        clk;
    logic        reset;
    logic [4:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  irq;
    logic        irq_any;

    logic [3:0]  addr8;
    logic        we8;
    logic [3:0]  be8;
    logic [31:0] wd8;
    logic [31:0] rd8;
    logic [3:0]  irq8;
    logic        irq_any8;

    int checks = 0;
    int errors = 0;
    logic [31:0] v;

    timer_array #(.NUM_TIMERS(4), .COUNT_W(32), .AW(5)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .BE(be), .WD(wd),
        .RD(rd), .IRQ(irq), .IRQ_any(irq_any)
    );

    timer_array #(.NUM_TIMERS(4), .COUNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .addr(addr8), .we(we8), .BE(be8), .WD(wd8),
        .RD(rd8), .IRQ(irq8), .IRQ_any(irq_any8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] ch, input logic [1:0] r, input logic [31:0] d, input logic [3:0] b);
        addr = {ch, r};
        wd   = d;
        be   = b;
        we   = 1'b1;
        step();
        we   = 1'b0;
        be   = 4'h0;
        wd   = 32'h0;
    endtask

    task automatic rdm(input logic [2:0] ch, input logic [1:0] r, output logic [31:0] d);
        addr = {ch, r};
        #1;
        d = rd;
    endtask

    task automatic wr8(input logic [1:0] ch, input logic [1:0] r, input logic [31:0] d, input logic [3:0] b);
        addr8 = {ch, r};
        wd8   = d;
        be8   = b;
        we8   = 1'b1;
        step();
        we8   = 1'b0;
        be8   = 4'h0;
        wd8   = 32'h0;
    endtask

    task automatic rd8m(input logic [1:0] ch, input logic [1:0] r, output logic [31:0] d);
        addr8 = {ch, r};
        #1;
        d = rd8;
    endtask

    initial begin
        reset = 1'b1;
        addr = 5'h0; we = 1'b0; be = 4'h0; wd = 32'h0;
        addr8 = 4'h0; we8 = 1'b0; be8 = 4'h0; wd8 = 32'h0;
        #2 reset = 1'b0;
        #1;
        check("rst_irq", {28'h0, irq}, 32'h0);
        check("rst_irq_any", {31'h0, irq_any}, 32'h0);
        rdm(3'd0, 2'd0, v); check("rst_ctrl0", v, 32'h0);
        rdm(3'd0, 2'd2, v); check("rst_count0", v, 32'h0);
        step();
        @(negedge clk) reset = 1'b1;
        step();

        // Channel 0 one-shot from 5 with interrupt enabled.
        wr(3'd0, 2'd1, 32'd5, 4'hF);
        wr(3'd0, 2'd0, 32'h9, 4'hF);
        for (int k = 1; k <= 6; k++) begin
            step();
            rdm(3'd0, 2'd2, v); check("os_count", v, 32'(6 - k));
            check("os_irq_early", {31'h0, irq[0]}, 32'h0);
        end
        step();
        check("os_irq7", {31'h0, irq[0]}, 32'h1);
        check("os_irq_any", {31'h0, irq_any}, 32'h1);
        rdm(3'd0, 2'd0, v); check("os_ctrl_en_clr", v, 32'h8);
        step();
        rdm(3'd0, 2'd2, v); check("os_count_hold", v, 32'h0);
        rdm(3'd0, 2'd3, v); check("os_status", v, 32'h1);
        wr(3'd0, 2'd3, 32'h1, 4'hF);
        check("os_w1c", {31'h0, irq[0]}, 32'h0);

        // Channel 1 auto-reload, period 4.
        wr(3'd1, 2'd1, 32'd3, 4'hF);
        wr(3'd1, 2'd0, 32'hB, 4'hF);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("ar_irq_pre", {31'h0, irq[1]}, 32'h0);
        end
        step();
        check("ar_irq_set", {31'h0, irq[1]}, 32'h1);
        rdm(3'd1, 2'd2, v); check("ar_reload", v, 32'd3);
        wr(3'd1, 2'd3, 32'h1, 4'hF);
        check("ar_w1c", {31'h0, irq[1]}, 32'h0);
        rdm(3'd1, 2'd2, v); check("ar_count2", v, 32'd2);
        step();
        step();
        rdm(3'd1, 2'd2, v); check("ar_count0", v, 32'd0);
        check("ar_irq_still0", {31'h0, irq[1]}, 32'h0);
        wr(3'd1, 2'd3, 32'h1, 4'hF);
        check("ar_set_wins", {31'h0, irq[1]}, 32'h1);
        rdm(3'd1, 2'd2, v); check("ar_reload2", v, 32'd3);
        wr(3'd1, 2'd0, 32'h0, 4'hF);
        step();
        step();
        rdm(3'd1, 2'd2, v); check("ar_frozen", v, 32'd3);
        rdm(3'd1, 2'd3, v); check("ar_pend_kept", v, 32'h1);
        wr(3'd1, 2'd3, 32'h1, 4'hF);

        // Channel 3 masked: pending visible, IRQ held off until IM set.
        wr(3'd3, 2'd1, 32'd1, 4'hF);
        wr(3'd3, 2'd0, 32'h1, 4'hF);
        step(); step(); step();
        rdm(3'd3, 2'd3, v); check("im_status", v, 32'h1);
        check("im_irq3", {31'h0, irq[3]}, 32'h0);
        check("im_irq_any", {31'h0, irq_any}, 32'h0);
        wr(3'd3, 2'd0, 32'h8, 4'hF);
        check("im_unmask", {31'h0, irq[3]}, 32'h1);
        check("im_unmask_any", {31'h0, irq_any}, 32'h1);
        wr(3'd3, 2'd3, 32'h1, 4'hF);
        check("im_cleared_any", {31'h0, irq_any}, 32'h0);

        // Out-of-range channel 5 and byte-lane PRESET writes.
        wr(3'd5, 2'd1, 32'hFFFF_FFFF, 4'hF);
        wr(3'd5, 2'd0, 32'h9, 4'hF);
        rdm(3'd5, 2'd1, v); check("oor_preset", v, 32'h0);
        rdm(3'd5, 2'd0, v); check("oor_ctrl", v, 32'h0);
        rdm(3'd1, 2'd1, v); check("oor_ch1_preset", v, 32'd3);
        rdm(3'd1, 2'd0, v); check("oor_ch1_ctrl", v, 32'h0);
        step(); step();
        check("oor_irq_any", {31'h0, irq_any}, 32'h0);
        wr(3'd2, 2'd1, 32'h1122_3344, 4'hF);
        wr(3'd2, 2'd1, 32'hAABB_CCDD, 4'h2);
        rdm(3'd2, 2'd1, v); check("be_preset", v, 32'h1122_CC44);
        wr(3'd2, 2'd2, 32'h1234_5678, 4'hF);
        rdm(3'd2, 2'd2, v); check("count_ro", v, 32'h0);

        // 8-bit free-run wraps 0x00 -> 0xFF and keeps counting.
        wr8(2'd2, 2'd1, 32'd2, 4'hF);
        wr8(2'd2, 2'd0, 32'hD, 4'hF);
        step(); step(); step();
        rd8m(2'd2, 2'd2, v); check("fr_count0", v, 32'h0);
        check("fr_irq_pre", {31'h0, irq8[2]}, 32'h0);
        step();
        rd8m(2'd2, 2'd2, v); check("fr_wrap", v, 32'hFF);
        check("fr_irq_wrap", {31'h0, irq8[2]}, 32'h1);
        step();
        rd8m(2'd2, 2'd2, v); check("fr_continue", v, 32'hFE);
        wr8(2'd1, 2'd1, 32'hFFFF_FFFF, 4'hF);
        rd8m(2'd1, 2'd1, v); check("fr_preset_width", v, 32'hFF);

        // Reset mid-count on channel 0 aborts without pending.
        wr(3'd0, 2'd0, 32'h9, 4'hF);
        step(); step(); step(); step();
        rdm(3'd0, 2'd2, v); check("rc_count2", v, 32'd2);
        #1 reset = 1'b0;
        #1;
        check("rc_irq", {28'h0, irq}, 32'h0);
        check("rc_irq_any", {31'h0, irq_any}, 32'h0);
        check("rc_irq_any8", {31'h0, irq_any8}, 32'h0);
        rdm(3'd0, 2'd2, v); check("rc_count", v, 32'h0);
        rdm(3'd0, 2'd0, v); check("rc_ctrl", v, 32'h0);
        rdm(3'd2, 2'd1, v); check("rc_preset2", v, 32'h0);
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < 10; k++) step();
        check("rc_post_irq_any", {31'h0, irq_any}, 32'h0);
        rdm(3'd0, 2'd3, v); check("rc_post_status", v, 32'h0);
        rdm(3'd0, 2'd2, v); check("rc_post_count", v, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
